// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store alignment unit.
package lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SEL_BYTE = 2'b01;
    localparam logic [1:0] SEL_HALF = 2'b11;
    localparam logic [1:0] SEL_WORD = 2'b00;

    typedef enum logic [1:0] {ST_IDLE, ST_LD2, ST_STB} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    // Reserved funct3 encodings fall through to word size.
    function automatic size_e acc_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

    // True when the memory can serve the access in a single cycle.
    function automatic logic is_direct(input logic we, input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_B:    return 1'b1;
            SZ_H:    return we ? ~off[0] : (off != 2'd3);
            default: return off == 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] store_sel(input size_e sz);
        case (sz)
            SZ_B:    return SEL_BYTE;
            SZ_H:    return SEL_HALF;
            default: return SEL_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align_load_extend.sv
// Extracts a byte/half/word from a little-endian {next,cur} word pair and extends it.
module load_extend
    import lsu_pkg::*;
(
    input  logic [2*XLEN-1:0] pair_i,
    input  logic [1:0]        off_i,
    input  logic [2:0]        funct3_i,
    output logic [XLEN-1:0]   data_o
);

    logic [2*XLEN-1:0] shifted;
    logic [XLEN-1:0]   win;

    assign shifted = pair_i >> {off_i, 3'b000};
    assign win     = shifted[XLEN-1:0];

    always_comb begin
        data_o = win;
        case (acc_size(funct3_i))
            SZ_B: data_o = funct3_i[2] ? {24'h0, win[7:0]} : {{24{win[7]}}, win[7:0]};
            SZ_H: data_o = funct3_i[2] ? {16'h0, win[15:0]} : {{16{win[15]}}, win[15:0]};
            default: data_o = win;
        endcase
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: splits crossing loads and misaligned stores into
// short sequences. Define LSU_MISALIGN_TRAP_EN to flag such accesses instead.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          stall,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          misalign_err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wr,
    output logic [1:0]    mem_store_sel,
    input  logic [DW-1:0] mem_rdata
);

    size_e          sz;
    logic [1:0]     off;
    logic           direct;
    logic [AW-1:0]  waddr;
    logic [2*DW-1:0] ext_pair;
    logic [DW-1:0]  ext_res;

    assign sz     = acc_size(req_funct3);
    assign off    = req_addr[1:0];
    assign direct = is_direct(req_we, sz, off);
    assign waddr  = {req_addr[AW-1:2], 2'b00};

    load_extend u_ext (
        .pair_i   (ext_pair),
        .off_i    (off),
        .funct3_i (req_funct3),
        .data_o   (ext_res)
    );

`ifdef LSU_MISALIGN_TRAP_EN

    always_comb begin
        stall         = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        misalign_err  = 1'b0;
        mem_addr      = req_addr;
        mem_wdata     = req_wdata;
        mem_wr        = 1'b0;
        mem_store_sel = store_sel(sz);
        ext_pair      = {{DW{1'b0}}, mem_rdata};
        if (rst_n && req_valid) begin
            resp_valid = 1'b1;
            if (!direct) begin
                misalign_err = 1'b1;
            end else if (req_we) begin
                mem_wr = 1'b1;
            end else begin
                mem_addr   = waddr;
                resp_rdata = ext_res;
            end
        end
    end

`else

    state_e         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [DW-1:0]  hold_q, hold_d;
    logic           last_byte;
    logic [DW-1:0]  st_shift;

    assign last_byte    = (cnt_q == ((sz == SZ_H) ? 2'd1 : 2'd3));
    assign st_shift     = req_wdata >> {cnt_q, 3'b000};
    assign misalign_err = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    // req_* are held stable by the stall, so the sequence keys off them directly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && !direct) begin
                    if (req_we) begin
                        state_d = ST_STB;
                        cnt_d   = 2'd1;
                    end else begin
                        state_d = ST_LD2;
                        hold_d  = mem_rdata;
                    end
                end
            end
            ST_LD2: state_d = ST_IDLE;
            ST_STB: begin
                if (last_byte) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall         = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        mem_addr      = req_addr;
        mem_wdata     = req_wdata;
        mem_wr        = 1'b0;
        mem_store_sel = store_sel(sz);
        ext_pair      = {{DW{1'b0}}, mem_rdata};
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (direct) begin
                        resp_valid = 1'b1;
                        if (req_we) begin
                            mem_wr = 1'b1;
                        end else begin
                            mem_addr   = waddr;
                            resp_rdata = ext_res;
                        end
                    end else if (req_we) begin
                        mem_wdata     = {{(DW-8){1'b0}}, req_wdata[7:0]};
                        mem_store_sel = SEL_BYTE;
                        mem_wr        = 1'b1;
                        stall         = 1'b1;
                    end else begin
                        mem_addr = waddr;
                        stall    = 1'b1;
                    end
                end
            end
            ST_LD2: begin
                mem_addr   = waddr + AW'(4);
                ext_pair   = {mem_rdata, hold_q};
                resp_rdata = ext_res;
                resp_valid = 1'b1;
            end
            ST_STB: begin
                mem_addr      = req_addr + AW'(cnt_q);
                mem_wdata     = {{(DW-8){1'b0}}, st_shift[7:0]};
                mem_store_sel = SEL_BYTE;
                mem_wr        = 1'b1;
                stall         = ~last_byte;
                resp_valid    = last_byte;
            end
            default: ;
        endcase
        // Outputs go quiet the moment reset asserts, even mid-sequence.
        if (!rst_n) begin
            stall      = 1'b0;
            resp_valid = 1'b0;
            mem_wr     = 1'b0;
        end
    end

`endif

endmodule
